plab3_mem_blocking_cache_base_ctrl: RTL and testbench

- FSM controller that sequences the 256 B, 16-line, 16 B/line direct-mapped write-back, write-allocate blocking cache datapath.
- Drives all datapath enables and selects, and owns the four val/rdy handshakes: cachereq, cacheresp, memreq and memresp.
- Holds the per-line valid and dirty bits.
- Pairs one-to-one with the base cache datapath inside the blocking cache top level.

---
 rtl/plab3_mem_blocking_cache_base_ctrl_if.sv | 20 ++
 rtl/plab3_mem_blocking_cache_base_ctrl.sv | 100 ++++++++++
 tb/tb_plab3_mem_blocking_cache_base_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/plab3_mem_blocking_cache_base_ctrl_if.sv
// plab3_mem_blocking_cache_base_ctrl_if: val/rdy handshakes on the cache request/response
// and memory request/response ports; the controller is the master side.
interface plab3_mem_blocking_cache_base_ctrl_if;
    logic cachereq_val;
    logic cachereq_rdy;
    logic cacheresp_val;
    logic cacheresp_rdy;
    logic memreq_val;
    logic memreq_rdy;
    logic memresp_val;
    logic memresp_rdy;
    modport master (
        input  cachereq_val, cacheresp_rdy, memreq_rdy, memresp_val,
        output cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy
    );
    modport slave (
        output cachereq_val, cacheresp_rdy, memreq_rdy, memresp_val,
        input  cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy
    );
endinterface

// File: rtl/plab3_mem_blocking_cache_base_ctrl.sv
// plab3_mem_blocking_cache_base_ctrl: Moore FSM sequencing the direct-mapped write-back
// blocking cache datapath; owns the per-line valid/dirty bits.
module plab3_mem_blocking_cache_base_ctrl #(
    parameter int nlines = 16
) (
    input  logic        clk,
    input  logic        reset,
    plab3_mem_blocking_cache_base_ctrl_if.master hs,
    input  logic [1:0]  cachereq_type,
    input  logic        tag_match,
    input  logic [31:0] addr_in,
    output logic        cachereq_en,
    output logic        tag_array_ren,
    output logic        tag_array_wen,
    output logic [2:0]  tag_array_wben,
    output logic        data_array_ren,
    output logic        data_array_wen,
    output logic [15:0] data_array_wben,
    output logic        memresp_en,
    output logic        is_refill,
    output logic        read_data_reg_en,
    output logic        read_tag_reg_en,
    output logic [1:0]  read_byte_sel,
    output logic        memreq_type,
    output logic [1:0]  memreq_type2
);
    localparam int iw = $clog2(nlines);
    localparam logic [3:0] IDLE = 4'd0, TC = 4'd1, IN = 4'd2, RD = 4'd3,
                           WD = 4'd4, EP = 4'd5, ER = 4'd6, EW = 4'd7,
                           RR = 4'd8, RW = 4'd9, RU = 4'd10, W = 4'd11;

    logic [3:0]        state, next_state;
    logic [nlines-1:0] valid, dirty;
    logic [iw-1:0]     idx;
    logic              hit, run;
    logic [15:0]       wmask;
    logic              unused_addr;

    assign idx         = addr_in[4 +: iw];
    assign hit         = valid[idx] && tag_match;
    assign run         = !reset;
    assign wmask       = 16'hF << {addr_in[3:2], 2'b00};
    assign unused_addr = ^{addr_in[31:4+iw], addr_in[1:0]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       next_state = hs.cachereq_val ? TC : IDLE;
            TC:         next_state = cachereq_type == 2'd2 ? IN
                                   : hit ? (cachereq_type == 2'd1 ? WD : RD)
                                   : (valid[idx] && dirty[idx]) ? EP : RR;
            IN, RD, WD: next_state = W;
            EP:         next_state = ER;
            ER:         next_state = hs.memreq_rdy ? EW : ER;
            EW:         next_state = hs.memresp_val ? RR : EW;
            RR:         next_state = hs.memreq_rdy ? RW : RR;
            RW:         next_state = hs.memresp_val ? RU : RW;
            RU:         next_state = TC;
            W:          next_state = hs.cacheresp_rdy ? IDLE : W;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            if (state == IN || state == RU) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (state == WD) dirty[idx] <= 1'b1;
            if (state == EW && hs.memresp_val) dirty[idx] <= 1'b0;
        end
    end

    // Handshakes and enables are forced low while reset is held, whatever the state.
    assign hs.cachereq_rdy  = run && state == IDLE;
    assign hs.cacheresp_val = run && state == W;
    assign hs.memreq_val    = run && (state == ER || state == RR);
    assign hs.memresp_rdy   = run && (state == EW || state == RW);
    assign cachereq_en      = run && state == IDLE;
    assign tag_array_ren    = run && (state == TC || state == EP);
    assign tag_array_wen    = run && (state == IN || state == RU);
    assign tag_array_wben   = 3'b111;
    assign data_array_ren   = run && (state == RD || state == EP);
    assign data_array_wen   = run && (state == IN || state == WD || state == RU);
    assign data_array_wben  = !run ? 16'h0 : state == RU ? 16'hFFFF
                            : (state == IN || state == WD) ? wmask : 16'h0;
    assign memresp_en       = run && state == RW;
    assign is_refill        = state == RU;
    assign read_data_reg_en = run && (state == RD || state == EP);
    assign read_tag_reg_en  = run && state == EP;
    assign read_byte_sel    = addr_in[3:2];
    assign memreq_type      = state == RR;
    assign memreq_type2     = {1'b0, state == ER};
endmodule

// File: tb/tb_plab3_mem_blocking_cache_base_ctrl.sv
// tb_plab3_mem_blocking_cache_base_ctrl: directed bench with a small tag-array/request-register
// model standing in for the datapath and a one-cycle memory.
module tb_plab3_mem_blocking_cache_base_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    plab3_mem_blocking_cache_base_ctrl_if h();

    logic [1:0]  req_type = 2'd0, cachereq_type;
    logic [31:0] req_addr = 32'h0, addr_in;
    logic        tag_match;
    logic        cachereq_en, tag_array_ren, tag_array_wen, data_array_ren, data_array_wen;
    logic        memresp_en, is_refill, read_data_reg_en, read_tag_reg_en, memreq_type;
    logic [2:0]  tag_array_wben;
    logic [15:0] data_array_wben;
    logic [1:0]  read_byte_sel, memreq_type2;
    logic [23:0] tag_mem [16];
    logic [23:0] victim;
    logic [31:0] mreq_addr;

    int n_chk = 0, n_pass = 0;
    int lat, nrd, nwr, drops, mstall, cstall;
    bit done;
    logic [1:0]  first_t2, rbs;
    logic [31:0] rd_addr, wr_addr;
    logic [15:0] wben_seen;

    plab3_mem_blocking_cache_base_ctrl dut (
        .clk(clk), .reset(reset), .hs(h),
        .cachereq_type(cachereq_type), .tag_match(tag_match), .addr_in(addr_in),
        .cachereq_en(cachereq_en), .tag_array_ren(tag_array_ren), .tag_array_wen(tag_array_wen),
        .tag_array_wben(tag_array_wben), .data_array_ren(data_array_ren),
        .data_array_wen(data_array_wen), .data_array_wben(data_array_wben),
        .memresp_en(memresp_en), .is_refill(is_refill), .read_data_reg_en(read_data_reg_en),
        .read_tag_reg_en(read_tag_reg_en), .read_byte_sel(read_byte_sel),
        .memreq_type(memreq_type), .memreq_type2(memreq_type2)
    );

    // Datapath stand-in: request registers, tag array and victim tag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) tag_mem[i] <= '0;
            victim        <= '0;
            addr_in       <= '0;
            cachereq_type <= '0;
        end else begin
            if (cachereq_en) begin
                addr_in       <= req_addr;
                cachereq_type <= req_type;
            end
            if (tag_array_wen) tag_mem[addr_in[7:4]] <= addr_in[31:8];
            if (read_tag_reg_en) victim <= tag_mem[addr_in[7:4]];
        end
    end

    assign tag_match = tag_mem[addr_in[7:4]] == addr_in[31:8];
    assign mreq_addr = {memreq_type ? addr_in[31:8] : victim, addr_in[7:4], 4'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One transaction, called at a negedge; inputs change and outputs are sampled at negedges.
    task automatic xact(input logic [1:0] t, input logic [31:0] a, input int rq_st,
                        input int rs_st, input bit abort);
        int c = 0;
        bit acc = 0, pend = 0, prev_mq = 0, prev_cr = 0;
        lat = 0; nrd = 0; nwr = 0; drops = 0; mstall = 0; cstall = 0; done = 0;
        first_t2 = 2'd3; rbs = 2'd0; rd_addr = '0; wr_addr = '0; wben_seen = '0;
        req_type = t; req_addr = a; h.cachereq_val = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (acc) begin
                c++;
                h.cachereq_val = 1'b0;
            end
            if (prev_mq && !h.memreq_val) drops++;
            if (prev_cr && !h.cacheresp_val) drops++;
            if (data_array_wen) wben_seen = data_array_wben;
            if (abort && h.memresp_rdy) return;
            h.memresp_val = pend;
            if (pend && h.memresp_rdy) pend = 0;
            h.memreq_rdy = h.memreq_val && rq_st == 0;
            if (h.memreq_val && rq_st > 0) begin
                rq_st--;
                mstall++;
            end
            if (h.memreq_val && h.memreq_rdy) begin
                pend = 1;
                if (first_t2 == 2'd3) first_t2 = memreq_type2;
                if (memreq_type2 == 2'd1) begin
                    nwr++;
                    wr_addr = mreq_addr;
                end else begin
                    nrd++;
                    rd_addr = mreq_addr;
                end
            end
            prev_mq = h.memreq_val && !h.memreq_rdy;
            h.cacheresp_rdy = h.cacheresp_val && rs_st == 0;
            if (h.cacheresp_val) begin
                if (lat == 0) begin
                    lat = c;
                    rbs = read_byte_sel;
                end
                if (rs_st > 0) begin
                    rs_st--;
                    cstall++;
                end else done = 1;
            end
            prev_cr = h.cacheresp_val && !h.cacheresp_rdy;
            if (h.cachereq_val && h.cachereq_rdy) acc = 1;
            @(negedge clk);
        end
        check("resp_done", 32'(done), 32'd1);
        h.cacheresp_rdy = 1'b0;
        h.memreq_rdy = 1'b0;
        h.memresp_val = 1'b0;
    endtask

    initial begin
        h.cachereq_val = 1'b0; h.cacheresp_rdy = 1'b0; h.memreq_rdy = 1'b0; h.memresp_val = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs", {h.cachereq_rdy, h.cacheresp_val, h.memreq_val, h.memresp_rdy,
                           cachereq_en, tag_array_wen, data_array_wen}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rdy", {h.cachereq_rdy, cachereq_en}, 32'h3);

        // Clean miss on an invalid line, then refill and re-check hit.
        xact(2'd0, 32'h0000_1004, 0, 0, 0);
        check("s1_lat", lat, 7);
        check("s1_nrd", nrd, 1);
        check("s1_nwr", nwr, 0);
        check("s1_rdaddr", rd_addr, 32'h0000_1000);
        check("s1_type2", first_t2, 0);
        check("s1_bytesel", rbs, 1);
        check("s1_refill_wben", wben_seen, 16'hFFFF);

        xact(2'd0, 32'h0000_100C, 0, 0, 0);
        check("s2_lat", lat, 3);
        check("s2_nomem", nrd + nwr, 0);
        check("s2_bytesel", rbs, 3);

        xact(2'd2, 32'h0000_0020, 0, 0, 0);
        check("s3_init_lat", lat, 3);
        check("s3_init_wben", wben_seen, 16'h000F);
        check("s3_nomem", nrd + nwr, 0);
        check("s3_valid2", dut.valid[2], 1);
        check("s3_dirty2", dut.dirty[2], 0);
        xact(2'd0, 32'h0000_0020, 0, 0, 0);
        check("s3_rd_lat", lat, 3);
        check("s3_rd_nomem", nrd + nwr, 0);

        xact(2'd1, 32'h0000_1008, 0, 0, 0);
        check("s4_wr_lat", lat, 3);
        check("s4_wr_wben", wben_seen, 16'h0F00);
        check("s4_dirty0", dut.dirty[0], 1);
        xact(2'd0, 32'h0000_2008, 0, 0, 0);
        check("s4_lat", lat, 10);
        check("s4_first_write", first_t2, 1);
        check("s4_nwr", nwr, 1);
        check("s4_wraddr", wr_addr, 32'h0000_1000);
        check("s4_nrd", nrd, 1);
        check("s4_rdaddr", rd_addr, 32'h0000_2000);
        check("s4_bytesel", rbs, 2);
        check("s4_dirty0_clr", dut.dirty[0], 0);
        check("s4_valid0", dut.valid[0], 1);

        xact(2'd0, 32'h0000_3004, 5, 3, 0);
        check("s5_lat", lat, 12);
        check("s5_drops", drops, 0);
        check("s5_mstall", mstall, 5);
        check("s5_cstall", cstall, 3);
        check("s5_nrd", nrd, 1);
        check("s5_nwr", nwr, 0);

        xact(2'd0, 32'h0000_4004, 0, 0, 1);
        check("s6_req_issued", nrd, 1);
        check("s6_in_rw", {h.memresp_rdy, memresp_en}, 32'h3);
        reset = 1'b1;
        h.memreq_rdy = 1'b0; h.memresp_val = 1'b0; h.cacheresp_rdy = 1'b0;
        @(negedge clk);
        check("s6_rst_outs", {h.cachereq_rdy, h.cacheresp_val, h.memreq_val, h.memresp_rdy,
                              memresp_en}, 32'h0);
        check("s6_state", dut.state, 0);
        check("s6_valid", dut.valid, 0);
        reset = 1'b0;
        @(negedge clk);
        xact(2'd0, 32'h0000_1004, 0, 0, 0);
        check("s6_lat", lat, 7);
        check("s6_nrd", nrd, 1);
        check("s6_nwr", nwr, 0);
        check("s6_rdaddr", rd_addr, 32'h0000_1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
